dpram_fifo_ctrl: RTL and testbench

Access controller that drives the write and read ports of the team's synchronous dual-port RAM (sync_dualport_ram) as a first-word-fall-through FIFO. It exposes valid/ready streams on both sides and generates wr_en/rd_en/addresses toward the RAM. It absorbs the RAM's 1-cycle read latency with a 2-entry output buffer, so it sustains 1 word/cycle. The RAM instance sits outside the block; this block is its only master.

---
 rtl/dpram_fifo_ctrl.sv | 147 ++++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external sync_dualport_ram.
// Define FIFO_ALMOST_FULL_EN to add a registered almost_full flag (threshold AFULL_THRESH).
module dpram_fifo_ctrl #(
  parameter int width     = 8,
  parameter int depth     = 16,
  parameter int addr_size = 4
`ifdef FIFO_ALMOST_FULL_EN
  ,
  parameter int AFULL_THRESH = depth - 2
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [width-1:0]     s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [width-1:0]     m_data,
  output logic                 ram_wr_en,
  output logic [addr_size-1:0] ram_wr_addr,
  output logic [width-1:0]     ram_data_in,
  output logic                 ram_rd_en,
  output logic [addr_size-1:0] ram_rd_addr,
  input  logic [width-1:0]     ram_data_out,
  output logic [addr_size+1:0] level,
  output logic                 almost_full
);

  localparam logic [addr_size:0] DEPTH_C = (addr_size+1)'(depth);

  function automatic logic [addr_size-1:0] ptr_inc(input logic [addr_size-1:0] p);
    return p + (addr_size)'(1);
  endfunction

  logic                 run;
  logic [addr_size-1:0] wr_ptr;
  logic [addr_size-1:0] rd_ptr;
  logic [addr_size:0]   ram_count;
  logic [addr_size:0]   ram_count_n;
  logic                 rd_pend;
  logic [1:0]           out_occ;
  logic [1:0]           out_occ_n;
  logic [2:0]           occ_pend;
  logic [width-1:0]     head_q;
  logic [width-1:0]     head_n;
  logic [width-1:0]     skid_q;
  logic [width-1:0]     skid_n;
  logic [addr_size+1:0] level_q;
  logic [addr_size+1:0] level_n;
  logic                 push;
  logic                 pop;

  // s_ready stays low until the first edge after reset release
  assign s_ready     = run && (ram_count < DEPTH_C);
  assign push        = s_valid && s_ready;
  assign m_valid     = (out_occ != 2'd0);
  assign m_data      = head_q;
  assign pop         = m_valid && m_ready;
  assign level       = level_q;

  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr;
  assign ram_data_in = s_data;
  assign ram_rd_addr = rd_ptr;

  // Issue a read only if its data is guaranteed a buffer slot when it returns
  always_comb begin
    occ_pend  = {1'b0, out_occ} + {2'b00, rd_pend} - {2'b00, pop};
    ram_rd_en = (ram_count != '0) && (occ_pend < 3'd2);
  end

  assign ram_count_n = ram_count + (addr_size+1)'(push) - (addr_size+1)'(ram_rd_en);

  // Output buffer: pop shifts skid to head, then returning read data fills the first free slot
  always_comb begin
    head_n    = head_q;
    skid_n    = skid_q;
    out_occ_n = out_occ;
    if (pop) begin
      head_n    = skid_q;
      out_occ_n = out_occ - 2'd1;
    end
    if (rd_pend) begin
      if (out_occ_n == 2'd0) begin
        head_n = ram_data_out;
      end else begin
        skid_n = ram_data_out;
      end
      out_occ_n = out_occ_n + 2'd1;
    end
  end

  assign level_n = (addr_size+2)'(ram_count_n) + (addr_size+2)'(ram_rd_en)
                 + (addr_size+2)'(out_occ_n);

  // Stage p0 -> p1: pointers, counts, read-pending flag and head word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      rd_pend   <= 1'b0;
      out_occ   <= 2'd0;
      head_q    <= '0;
      level_q   <= '0;
    end else begin
      run       <= 1'b1;
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (ram_rd_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      ram_count <= ram_count_n;
      rd_pend   <= ram_rd_en;
      out_occ   <= out_occ_n;
      head_q    <= head_n;
      level_q   <= level_n;
    end
  end

  // Skid entry is only meaningful while out_occ says so, so it carries no reset
  always_ff @(posedge clk) begin
    skid_q <= skid_n;
  end

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [addr_size+1:0] AFULL_C = (addr_size+2)'(AFULL_THRESH);

  logic afull_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (level_n >= AFULL_C);
    end
  end

  assign almost_full = afull_q;
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_dpram_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       ram_wr_en;
  logic [3:0] ram_wr_addr;
  logic [7:0] ram_data_in;
  logic       ram_rd_en;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_data_out;
  logic [5:0] level;
  logic       almost_full;

  dpram_fifo_ctrl #(
    .width(8), .depth(16), .addr_size(4)
`ifdef FIFO_ALMOST_FULL_EN
    , .AFULL_THRESH(14)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out),
    .level(level), .almost_full(almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous dual-port RAM, 1-cycle read latency
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
    if (ram_rd_en) ram_data_out <= mem[ram_rd_addr];
  end

  int n_vec = 0;
  int n_err = 0;
  int push_total = 0;
  int pop_total = 0;
  int rd_total = 0;
  bit run_tb = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1; handshakes are recorded at the following negedge
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(negedge clk);
    chk("wr_en", 32'(ram_wr_en), 32'(s_valid && s_ready));
    if (s_valid && s_ready) begin
      chk("wr_addr", 32'(ram_wr_addr), 32'(push_total % 16));
      chk("wr_data", 32'(ram_data_in), 32'(s_data));
      exp_q.push_back(s_data);
      push_total++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (push_total != pop_total && n < bound) begin
      step(1'b0, 8'd0, 1'b1);
      n++;
    end
    chk("drain_held", 32'(push_total - pop_total), 32'd0);
  endtask

  // Monitor: pops the scoreboard on each output handshake, checks stall stability
  initial begin
    bit stall;
    logic [7:0] stall_data;
    stall = 0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 0;
      end else begin
        if (stall) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", 32'(m_data), 32'(stall_data));
        end
        if (ram_rd_en) begin
          chk("rd_addr", 32'(ram_rd_addr), 32'(rd_total % 16));
          rd_total++;
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pop_empty: got %0d expected no word", m_data);
          end else begin
            chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
          end
          pop_total++;
        end
        stall = m_valid && !m_ready;
        stall_data = m_data;
      end
    end
  end

  // Occupancy checker: level, capacity-based s_ready and almost_full
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("level", 32'(level), 32'(push_total - pop_total));
        if (run_tb) chk("s_ready_cap", 32'(s_ready), 32'((push_total - pop_total) < 18));
`ifdef FIFO_ALMOST_FULL_EN
        chk("almost_full", 32'(almost_full), 32'(level >= 6'd14));
`else
        chk("almost_full_off", 32'(almost_full), 32'd0);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int w;
    int n;
    logic [7:0] d;
    rst = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    rst = 1'b1;
    step(1'b0, 8'd0, 1'b0);
    run_tb = 1;
    chk("s_ready_after_rel", 32'(s_ready), 32'd1);

    // Single word latency
    step(1'b1, 8'd200, 1'b1);
    chk("t1_rd_en", 32'(ram_rd_en), 32'd1);
    chk("t1_rd_addr", 32'(ram_rd_addr), 32'd0);
    chk("t1_m_valid_e", 32'(m_valid), 32'd0);
    step(1'b0, 8'd0, 1'b1);
    chk("t1_m_valid_e1", 32'(m_valid), 32'd0);
    step(1'b0, 8'd0, 1'b1);
    chk("t1_m_valid_e2", 32'(m_valid), 32'd1);
    chk("t1_m_data_e2", 32'(m_data), 32'd200);
    step(1'b0, 8'd0, 1'b1);
    chk("t1_level_end", 32'(level), 32'd0);

    // Fill to capacity with the output stalled, then drain gap-free
    base = push_total;
    w = 1;
    for (int i = 0; i < 25; i++) begin
      n = push_total;
      step(1'b1, 8'(w), 1'b0);
      if (push_total != n) w++;
    end
    chk("fill_count", 32'(push_total - base), 32'd18);
    chk("fill_s_ready", 32'(s_ready), 32'd0);
    chk("fill_level", 32'(level), 32'd18);
    base = pop_total;
    repeat (18) step(1'b0, 8'd0, 1'b1);
    chk("drain_gapless", 32'(pop_total - base), 32'd18);
    drain(10);

    // Continuous streaming across pointer wrap
    base = push_total;
    n = pop_total;
    d = 8'($urandom);
    for (int i = 0; i < 44; i++) begin
      w = push_total;
      step(1'b1 && (push_total - base < 40), d, 1'b1);
      if (push_total != w) d = 8'($urandom);
    end
    chk("stream_pushes", 32'(push_total - base), 32'd40);
    chk("stream_pops", 32'(pop_total - n), 32'd40);

    // Random valid/ready on a 30-word stream
    base = push_total;
    n = 0;
    d = 8'($urandom);
    while ((push_total - base) < 30 && n < 600) begin
      w = push_total;
      step(1'b1 && (($urandom % 4) != 0), d, 1'b1 && (($urandom % 2) != 0));
      if (push_total != w) d = 8'($urandom);
      n++;
    end
    chk("rand_pushes", 32'(push_total - base), 32'd30);
    drain(60);

    // Reset mid-stream with words held and a read in flight
    for (int i = 0; i < 5; i++) step(1'b1, 8'(50 + i), 1'b0);
    s_valid = 1'b1;
    s_data = 8'd99;
    rst = 1'b0;
    exp_q.delete();
    push_total = 0;
    pop_total = 0;
    rd_total = 0;
    run_tb = 0;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("mid_rst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    rst = 1'b1;
    step(1'b0, 8'd0, 1'b0);
    run_tb = 1;
    step(1'b1, 8'd70, 1'b1);
    drain(10);
    chk("post_rst_pops", 32'(pop_total), 32'd1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
